// File: rtl/watch_pkg.sv
// Shared mode encoding and BCD limits for the watch time counter.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_SET  = 2'd2
  } watchMode_e;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter, 00..MAX, with clear and carry-out pulse.
module bcd_mod_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  always_comb carry = inc && !clr && (value == MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (value == MAX)
        value <= 8'h00;
      else if (value[3:0] == 4'd9)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/watch_time_counter.sv
// Watch timekeeper: STOP/RUN/SET modes, 1 Hz prescaler, BCD hh:mm:ss.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int CLK_HZ = 32768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       tick_1hz,
  output logic       colon_on
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

  watchMode_e mode, modeNext;
  logic [PW-1:0] pre, preNext;
  logic incMinQ, incHourQ;
  logic inSet, preWrap;
  logic minEdge, hourEdge;
  logic secCarry, minCarry;
  logic minInc, hourInc;

  always_comb begin
    if (set_mode)
      modeNext = MODE_SET;
    else if (run)
      modeNext = MODE_RUN;
    else
      modeNext = MODE_STOP;
  end

  always_comb begin
    inSet   = (mode == MODE_SET);
    preWrap = (mode == MODE_RUN) && (32'(pre) == CLK_HZ - 1);
    preNext = pre;
    if (modeNext == MODE_SET)
      preNext = '0;
    else if (mode == MODE_RUN)
      preNext = preWrap ? '0 : pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_STOP;
      pre      <= '0;
      tick_1hz <= 1'b0;
      colon_on <= 1'b1;
      incMinQ  <= 1'b0;
      incHourQ <= 1'b0;
    end else begin
      mode     <= modeNext;
      pre      <= preNext;
      // A second that ends as SET is entered is discarded.
      tick_1hz <= preWrap && (modeNext != MODE_SET);
      colon_on <= (modeNext != MODE_RUN) ||
                  (32'(preNext) < CLK_HZ / 2);
      incMinQ  <= inc_min;
      incHourQ <= inc_hour;
    end
  end

  always_comb begin
    minEdge  = inSet && inc_min && !incMinQ;
    hourEdge = inSet && inc_hour && !incHourQ;
    minInc   = secCarry || minEdge;
    // Setting minutes must never ripple into hours.
    hourInc  = hourEdge || (minCarry && !inSet);
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) uSec (
    .clk  (clk),
    .rst  (rst),
    .inc  (tick_1hz),
    .clr  (minEdge),
    .value(sec_bcd),
    .carry(secCarry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) uMin (
    .clk  (clk),
    .rst  (rst),
    .inc  (minInc),
    .clr  (1'b0),
    .value(min_bcd),
    .carry(minCarry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) uHour (
    .clk  (clk),
    .rst  (rst),
    .inc  (hourInc),
    .clr  (1'b0),
    .value(hour_bcd),
    .carry()
  );

endmodule

// File: tb/tb_watch_time_counter.sv
// Scoreboard bench for watch_time_counter with CLK_HZ = 4.
module tb_watch_time_counter;

  logic clk = 1'b0;
  logic rst, run, set_mode, inc_min, inc_hour;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic tick_1hz, colon_on;

  watch_time_counter #(.CLK_HZ(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .set_mode(set_mode),
    .inc_min (inc_min),
    .inc_hour(inc_hour),
    .sec_bcd (sec_bcd),
    .min_bcd (min_bcd),
    .hour_bcd(hour_bcd),
    .tick_1hz(tick_1hz),
    .colon_on(colon_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] s, m, h;
    logic       t, c;
    logic [2:0] mask;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int applied = 0;
  int miscompares = 0;

  logic [7:0] secT[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
  logic       tickT[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
  logic       colT[10]  = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] toBcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [7:0] s, m, h,
                         input logic t, c,
                         input logic [2:0] mask,
                         input string nm);
    exp_t e;
    e.cyc = cyc; e.s = s; e.m = m; e.h = h;
    e.t = t; e.c = c; e.mask = mask; e.nm = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [23:0] tm;
    tm = {hour_bcd, min_bcd, sec_bcd};
    applied++;
    for (int i = 0; i < 6; i++) begin
      if (!(tm[i*4 +: 4] <= 4'd9)) begin
        miscompares++;
        $display("FAIL bcdNibble cyc=%0d got %h:%h:%h required nibbles <= 9",
                 cyc, hour_bcd, min_bcd, sec_bcd);
        break;
      end
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        applied++;
        miscompares++;
        $display("FAIL %s stale expectation cyc=%0d now=%0d", e.nm, e.cyc, cyc);
        continue;
      end
      if (e.mask[0]) begin
        applied++;
        if ({hour_bcd, min_bcd, sec_bcd} !== {e.h, e.m, e.s}) begin
          miscompares++;
          $display("FAIL %s time cyc=%0d got %h:%h:%h required %h:%h:%h",
                   e.nm, cyc, hour_bcd, min_bcd, sec_bcd, e.h, e.m, e.s);
        end
      end
      if (e.mask[1]) begin
        applied++;
        if (tick_1hz !== e.t) begin
          miscompares++;
          $display("FAIL %s tick cyc=%0d got %b required %b",
                   e.nm, cyc, tick_1hz, e.t);
        end
      end
      if (e.mask[2]) begin
        applied++;
        if (colon_on !== e.c) begin
          miscompares++;
          $display("FAIL %s colon cyc=%0d got %b required %b",
                   e.nm, cyc, colon_on, e.c);
        end
      end
    end
  end

  initial begin
    int m, total, s, r;
    rst = 1'b1; run = 1'b0; set_mode = 1'b0;
    inc_min = 1'b0; inc_hour = 1'b0;
    step();
    step();
    pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "reset");

    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      pushExp(secT[i], 8'h00, 8'h00, tickT[i], colT[i], 3'b111, "run8");
    end

    run = 1'b0;
    step();
    pushExp(8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "stop");
    repeat (5) begin
      step();
      pushExp(8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "stopHold");
    end
    run = 1'b1;
    step(); pushExp(8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 3'b111, "resume1");
    step(); pushExp(8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 3'b111, "resume2");
    step(); pushExp(8'h02, 8'h00, 8'h00, 1'b1, 1'b1, 3'b111, "resumeTick");
    step(); pushExp(8'h03, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "resumeSec");

    set_mode = 1'b1;
    step();
    pushExp(8'h03, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "setEntry");
    inc_min = 1'b1;
    repeat (10) begin
      step();
      pushExp(8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 3'b111, "minHeld");
    end
    inc_min = 1'b0;
    step();
    pushExp(8'h00, 8'h01, 8'h00, 1'b0, 1'b1, 3'b111, "minRelease");

    m = 1;
    for (int k = 0; k < 58; k++) begin
      inc_min = 1'b1;
      step();
      m++;
      pushExp(8'h00, toBcd(m), 8'h00, 1'b0, 1'b1, 3'b001, "minStep");
      inc_min = 1'b0;
      step();
    end
    inc_min = 1'b1;
    step();
    pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b001, "minWrap");
    inc_min = 1'b0;
    step();

    for (int k = 1; k <= 24; k++) begin
      inc_hour = 1'b1;
      step();
      pushExp(8'h00, 8'h00, toBcd(k % 24), 1'b0, 1'b1, 3'b001, "hourStep");
      inc_hour = 1'b0;
      step();
    end

    inc_min = 1'b1; inc_hour = 1'b1;
    step();
    pushExp(8'h00, 8'h01, 8'h01, 1'b0, 1'b1, 3'b001, "bothEdges");
    inc_min = 1'b0; inc_hour = 1'b0;
    step();

    for (int k = 0; k < 58; k++) begin
      inc_min = 1'b1;
      inc_hour = (k < 22);
      step();
      pushExp(8'h00, toBcd(k + 2), toBcd((k < 22) ? k + 2 : 23),
              1'b0, 1'b1, 3'b001, "preload");
      inc_min = 1'b0; inc_hour = 1'b0;
      step();
    end

    set_mode = 1'b0; run = 1'b1;
    for (r = 1; r <= 250; r++) begin
      inc_min = (r == 247);
      inc_hour = (r == 247);
      step();
      s = (r >= 2) ? (r - 2) / 4 : 0;
      total = (23 * 3600 + 59 * 60 + s) % 86400;
      pushExp(toBcd(total % 60), toBcd((total / 60) % 60), toBcd(total / 3600),
              (r >= 5) && ((r - 1) % 4 == 0), ((r - 1) % 4) < 2,
              3'b111, "rollover");
    end
    inc_min = 1'b0; inc_hour = 1'b0;

    run = 1'b0; set_mode = 1'b1;
    step();
    pushExp(8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "setAgain");
    inc_min = 1'b1; inc_hour = 1'b1; rst = 1'b1;
    step();
    pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "rstInSet");
    rst = 1'b0;
    step();
    pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "postRst");
    step();
    pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "postRstHeld");

    inc_min = 1'b0; inc_hour = 1'b0; set_mode = 1'b0;
    step();
    pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "stopIdle");
    inc_min = 1'b1; inc_hour = 1'b1;
    step();
    pushExp(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b111, "stopIgnore");

    repeat (3) step();
    if (sb.size() != 0) begin
      applied++;
      miscompares++;
      $display("FAIL drain got %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
